// File: rtl/rx_frame_buffer.sv
`default_nettype none
// ============================================================================
// rx_frame_buffer : store-and-forward RX frame buffer. Forwards whole frames
//                   that end clean and fit; silently drops errored/oversized.
// Rev 1.0
// ============================================================================
module rx_frame_buffer #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  s00_axis_aclk,
  input  logic                  s00_axis_areset,
  input  logic                  s00_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s00_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s00_axis_tstrb,
  input  logic                  s00_axis_tlast,
  input  logic                  s00_axis_tuser,
  output logic                  s00_axis_tready,
  output logic                  m00_axis_tvalid,
  input  logic                  m00_axis_tready,
  output logic [DATA_WIDTH-1:0] m00_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m00_axis_tstrb,
  output logic                  m00_axis_tlast,
  output logic [31:0]           stat_frames_ok,
  output logic [31:0]           stat_frames_bad,
  output logic [31:0]           stat_frames_ovf
);

  localparam int ENTRY_W = DATA_WIDTH + KEEP_WIDTH + 1;
  localparam int PTR_W   = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_DEPTH = PTR_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STORE   = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t             state;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] ram_q;
  logic               q_valid;
  logic               in_ready;
  logic [PTR_W-1:0]   wr_spec;
  logic [PTR_W-1:0]   wr_commit;
  logic [PTR_W-1:0]   rd;
  logic [PTR_W-1:0]   used;
  logic               full;
  logic               beat;
  logic               wr_en;
  logic               has_data;
  logic               out_free;
  logic               load_out;
  logic               rd_en;

  assign s00_axis_tready = in_ready;
  assign beat            = s00_axis_tvalid && in_ready;
  assign used            = wr_spec - rd;
  assign full            = (used == PTR_DEPTH);
  assign wr_en           = beat && (state != DISCARD) && !full;

  // Egress: RAM read stage (ram_q/q_valid) feeding the output register.
  // rd only ever chases wr_commit, so uncommitted beats stay invisible.
  assign has_data = (rd != wr_commit);
  assign out_free = !m00_axis_tvalid || m00_axis_tready;
  assign load_out = q_valid && out_free;
  assign rd_en    = has_data && (!q_valid || load_out);

  always_ff @(posedge s00_axis_aclk) begin
    if (wr_en) begin
      mem[wr_spec[ADDR_WIDTH-1:0]] <= {s00_axis_tlast, s00_axis_tstrb, s00_axis_tdata};
    end
    if (rd_en) begin
      ram_q <= mem[rd[ADDR_WIDTH-1:0]];
    end
  end

  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      state           <= IDLE;
      in_ready        <= 1'b0;
      wr_spec         <= '0;
      wr_commit       <= '0;
      stat_frames_ok  <= '0;
      stat_frames_bad <= '0;
      stat_frames_ovf <= '0;
    end else begin
      in_ready <= 1'b1;
      if (beat) begin
        case (state)
          IDLE, STORE: begin
            if (full) begin
              wr_spec <= wr_commit;
              if (s00_axis_tlast) begin
                stat_frames_ovf <= stat_frames_ovf + 32'd1;
                state           <= IDLE;
              end else begin
                state <= DISCARD;
              end
            end else if (s00_axis_tlast) begin
              if (s00_axis_tuser) begin
                wr_spec         <= wr_commit;
                stat_frames_bad <= stat_frames_bad + 32'd1;
              end else begin
                wr_spec        <= wr_spec + PTR_ONE;
                wr_commit      <= wr_spec + PTR_ONE;
                stat_frames_ok <= stat_frames_ok + 32'd1;
              end
              state <= IDLE;
            end else begin
              wr_spec <= wr_spec + PTR_ONE;
              state   <= STORE;
            end
          end
          DISCARD: begin
            // wr_spec was already rewound when the overflow was detected
            if (s00_axis_tlast) begin
              stat_frames_ovf <= stat_frames_ovf + 32'd1;
              state           <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      rd              <= '0;
      q_valid         <= 1'b0;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tdata  <= '0;
      m00_axis_tstrb  <= '0;
      m00_axis_tlast  <= 1'b0;
    end else begin
      if (rd_en) begin
        rd      <= rd + PTR_ONE;
        q_valid <= 1'b1;
      end else if (load_out) begin
        q_valid <= 1'b0;
      end
      if (load_out) begin
        m00_axis_tvalid <= 1'b1;
        m00_axis_tlast  <= ram_q[ENTRY_W-1];
        m00_axis_tstrb  <= ram_q[DATA_WIDTH +: KEEP_WIDTH];
        m00_axis_tdata  <= ram_q[DATA_WIDTH-1:0];
      end else if (m00_axis_tready) begin
        m00_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_buffer.sv
`default_nettype none
// ============================================================================
// tb_rx_frame_buffer : self-checking bench for rx_frame_buffer (scoreboard +
//                      table-driven frame vectors). Rev 1.0
// ============================================================================
module tb_rx_frame_buffer;

  localparam int DW    = 512;
  localparam int KW    = DW / 8;
  localparam int DEPTH = 256;
  localparam int EW    = DW + KW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_tvalid = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tstrb = '0;
  logic          s_tlast = 1'b0;
  logic          s_tuser = 1'b0;
  logic          s_tready;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tstrb;
  logic          m_tlast;
  logic [31:0]   st_ok, st_bad, st_ovf;

  int            n_total = 0;
  int            n_bad = 0;
  int            rx_count = 0;
  bit            rand_rdy = 1'b0;
  logic [EW-1:0] sb[$];
  logic          stall_pending = 1'b0;
  logic [EW-1:0] held = '0;

  typedef struct {
    int len;
    bit tuser;
    int exp_ok;
    int exp_bad;
    int exp_ovf;
    int exp_beats;
  } vec_t;

  always #5 clk = ~clk;

  rx_frame_buffer #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEPTH(DEPTH)) dut (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .s00_axis_tvalid (s_tvalid),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tstrb  (s_tstrb),
    .s00_axis_tlast  (s_tlast),
    .s00_axis_tuser  (s_tuser),
    .s00_axis_tready (s_tready),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tready (m_tready),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tstrb  (m_tstrb),
    .m00_axis_tlast  (m_tlast),
    .stat_frames_ok  (st_ok),
    .stat_frames_bad (st_bad),
    .stat_frames_ovf (st_ovf)
  );

  task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  // Output monitor: scoreboard pop plus hold-while-stalled checks
  always @(negedge clk) begin
    if (rst) begin
      stall_pending = 1'b0;
    end else begin
      if (stall_pending) begin
        check("stall_valid", m_tvalid, 1);
        check("stall_hold", {m_tlast, m_tstrb, m_tdata}, held);
      end
      if (m_tvalid && m_tready) begin
        rx_count++;
        if (sb.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL unexpected_beat: got %0h expected none", {m_tlast, m_tstrb, m_tdata});
        end else begin
          check("beat", {m_tlast, m_tstrb, m_tdata}, sb.pop_front());
        end
      end
      stall_pending = m_tvalid && !m_tready;
      held          = {m_tlast, m_tstrb, m_tdata};
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) m_tready = 1'($urandom_range(1));
    end
  end

  task automatic do_reset();
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_tready", s_tready, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_bus", {m_tlast, m_tstrb, m_tdata}, 0);
    check("rst_stats", {st_ok, st_bad, st_ovf}, 0);
    sb.delete();
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("tready_after_rst", s_tready, 1);
  endtask

  // Drives one frame; expected beats enter the scoreboard only if it should survive
  task automatic send_frame(input int len, input bit bad, input bit expect_out, input int gap_pct);
    logic [EW-1:0] beats[$];
    for (int i = 0; i < len; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_tdata  = rand_data();
      s_tstrb  = (i == len - 1) ? KW'({$urandom, $urandom}) : '1;
      s_tlast  = (i == len - 1);
      s_tuser  = (i == len - 1) ? bad : 1'($urandom_range(1));
      s_tvalid = 1'b1;
      beats.push_back({s_tlast, s_tstrb, s_tdata});
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    if (expect_out) begin
      foreach (beats[k]) sb.push_back(beats[k]);
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || m_tvalid) && t < 20000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_empty", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int   base;
    int   n;
    int   nb;
    vec_t tbl [6];

    tbl[0] = '{4,  1'b0, 1, 0, 0, 4};
    tbl[1] = '{5,  1'b1, 1, 1, 0, 4};
    tbl[2] = '{2,  1'b0, 2, 1, 0, 6};
    tbl[3] = '{1,  1'b1, 2, 2, 0, 6};
    tbl[4] = '{1,  1'b0, 3, 2, 0, 7};
    tbl[5] = '{40, 1'b0, 4, 2, 0, 47};

    // Good frames 1/24/3 with first-beat latency on the 1-beat frame
    do_reset();
    base     = rx_count;
    s_tdata  = rand_data();
    s_tstrb  = '1;
    s_tlast  = 1'b1;
    s_tuser  = 1'b0;
    s_tvalid = 1'b1;
    sb.push_back({s_tlast, s_tstrb, s_tdata});
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("latency_tvalid", m_tvalid, 1);
    send_frame(24, 1'b0, 1'b1, 0);
    send_frame(3, 1'b0, 1'b1, 0);
    drain();
    check("t1_ok", st_ok, 3);
    check("t1_beats", rx_count - base, 28);

    // Table of frames with cumulative stats
    do_reset();
    base = rx_count;
    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].len, tbl[i].tuser, !tbl[i].tuser, 20);
      drain();
      check("tbl_ok", st_ok, tbl[i].exp_ok);
      check("tbl_bad", st_bad, tbl[i].exp_bad);
      check("tbl_ovf", st_ovf, tbl[i].exp_ovf);
      check("tbl_beats", rx_count - base, tbl[i].exp_beats);
    end

    // Stalled output: 10 x 24 beats fit, the 11th frame overflows
    do_reset();
    m_tready = 1'b0;
    base     = rx_count;
    for (int f = 0; f < 10; f++) send_frame(24, 1'b0, 1'b1, 0);
    send_frame(24, 1'b0, 1'b0, 0);
    repeat (5) @(posedge clk);
    #1;
    check("stall_ok", st_ok, 10);
    check("stall_ovf", st_ovf, 1);
    check("stall_no_output", rx_count - base, 0);
    m_tready = 1'b1;
    n = 0;
    while (rx_count - base < 240 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("release_beats", rx_count - base, 240);
    check("release_no_bubble", n, 240);
    drain();

    // Frame longer than the buffer, then a small good frame
    base = rx_count;
    send_frame(300, 1'b0, 1'b0, 0);
    repeat (4) @(posedge clk);
    #1;
    check("long_ovf", st_ovf, 2);
    check("long_no_output", rx_count - base, 0);
    send_frame(2, 1'b0, 1'b1, 0);
    drain();
    check("after_long_ok", st_ok, 11);
    check("after_long_beats", rx_count - base, 2);

    // Random traffic with random back-pressure
    do_reset();
    rand_rdy = 1'b1;
    nb = 0;
    for (int f = 0; f < 1000; f++) begin
      int  len;
      bit  b;
      int  t;
      len = int'($urandom_range(1, 40));
      b   = ($urandom_range(99) < 10);
      t   = 0;
      while (sb.size() + len > DEPTH && t < 5000) begin
        @(posedge clk);
        #1;
        t++;
      end
      check("space_wait", (sb.size() + len <= DEPTH), 1);
      send_frame(len, b, !b, 25);
      if (b) nb++;
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    drain();
    check("rand_ok", st_ok, 1000 - nb);
    check("rand_bad", st_bad, nb);
    check("rand_ovf", st_ovf, 0);
    check("rand_sum", st_ok + st_bad + st_ovf, 1000);

    // Reset while a frame is half stored and a committed frame is queued
    m_tready = 1'b0;
    send_frame(3, 1'b0, 1'b1, 0);
    for (int i = 0; i < 5; i++) begin
      s_tdata  = rand_data();
      s_tstrb  = '1;
      s_tlast  = 1'b0;
      s_tvalid = 1'b1;
      @(posedge clk);
      #1;
    end
    check("pre_rst_tvalid", m_tvalid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_tvalid", m_tvalid, 0);
    sb.delete();
    s_tvalid = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_stats", {st_ok, st_bad, st_ovf}, 0);
    check("mid_rst_tready", s_tready, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    base     = rx_count;
    repeat (10) @(posedge clk);
    #1;
    check("no_stale_beats", rx_count - base, 0);
    send_frame(4, 1'b0, 1'b1, 0);
    drain();
    check("post_rst_ok", st_ok, 1);
    check("post_rst_beats", rx_count - base, 4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
